// File: rtl/output_accumulator_classifier_folded.sv
// Folded output accumulator/classifier.
// Each accepted frame is processed one class group per cycle. Each group
// popcount is folded into a leaky, saturating per-class accumulator. The
// block returns the argmax class and its score through a valid/ready
// handshake.
module output_accumulator_classifier_folded #(
  parameter int NET_WIDTH   = 8000,
  parameter int NUM_CLASSES = 10,
  parameter int ACC_WIDTH   = 16,
  parameter int DECAY_SHIFT = 2
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [NET_WIDTH-1:0]           net_i,
  input  logic                           inp_valid_i,
  output logic                           inp_ready_o,
  input  logic                           clear_i,
  output logic [$clog2(NUM_CLASSES)-1:0] class_out_o,
  output logic [ACC_WIDTH-1:0]           score_o,
  output logic                           out_valid_o,
  input  logic                           out_ready_i
);

  localparam int GROUP_WIDTH = NET_WIDTH / NUM_CLASSES;
  localparam int USED_WIDTH  = GROUP_WIDTH * NUM_CLASSES;
  localparam int IDX_W       = $clog2(NUM_CLASSES);
  localparam int POP_W       = $clog2(GROUP_WIDTH + 1);
  // One guard bit above the wider of accumulator and popcount, so the sum never wraps.
  localparam int SUM_W       = ((ACC_WIDTH > POP_W) ? ACC_WIDTH : POP_W) + 1;
  localparam logic [SUM_W-1:0] SAT_MAX  = {{(SUM_W-ACC_WIDTH){1'b0}}, {ACC_WIDTH{1'b1}}};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

  // Number of set bits in one class group.
  function automatic logic [POP_W-1:0] popcount(input logic [GROUP_WIDTH-1:0] bits);
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < GROUP_WIDTH; i++) begin
      cnt = cnt + POP_W'(bits[i]);
    end
    return cnt;
  endfunction

  state_e                 state_q, state_d;
  logic [USED_WIDTH-1:0]  frame_q, frame_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [ACC_WIDTH-1:0]   acc_q [NUM_CLASSES];
  logic [ACC_WIDTH-1:0]   acc_d [NUM_CLASSES];
  logic [ACC_WIDTH-1:0]   max_score_q, max_score_d;
  logic [IDX_W-1:0]       max_class_q, max_class_d;
  logic                   inp_ready_q, inp_ready_d;
  logic                   out_valid_q, out_valid_d;

  logic [POP_W-1:0]       pop_s;
  logic [ACC_WIDTH-1:0]   cur_acc_s;
  logic [SUM_W-1:0]       sum_s;
  logic [ACC_WIDTH-1:0]   new_acc_s;

  // Leaky update of the accumulator selected by the class index.
  // The frame buffer is shifted down one group per cycle, so the current group is always the low bits.
  always_comb begin
    pop_s     = popcount(frame_q[GROUP_WIDTH-1:0]);
    cur_acc_s = acc_q[idx_q];
    sum_s     = SUM_W'(cur_acc_s) - SUM_W'(cur_acc_s >> DECAY_SHIFT) + SUM_W'(pop_s);
    if (sum_s > SAT_MAX) begin
      new_acc_s = {ACC_WIDTH{1'b1}};
    end else begin
      new_acc_s = sum_s[ACC_WIDTH-1:0];
    end
  end

  // Next-state and datapath control for the IDLE/COUNT/OUT sequence.
  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    idx_d       = idx_q;
    max_score_d = max_score_q;
    max_class_d = max_class_q;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      acc_d[c] = acc_q[c];
    end

    case (state_q)
      ST_IDLE: begin
        // A clear wipes history at this edge; a frame accepted at the same edge then counts from zero.
        for (int c = 0; c < NUM_CLASSES; c++) begin
          acc_d[c] = clear_i ? {ACC_WIDTH{1'b0}} : acc_q[c];
        end
        if (inp_valid_i) begin
          frame_d     = net_i[USED_WIDTH-1:0];
          idx_d       = '0;
          max_score_d = '0;
          max_class_d = '0;
          state_d     = ST_COUNT;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_COUNT: begin
        acc_d[idx_q] = new_acc_s;
        frame_d      = frame_q >> GROUP_WIDTH;
        // Strict greater-than keeps the lowest index on ties.
        if (new_acc_s > max_score_q) begin
          max_score_d = new_acc_s;
          max_class_d = idx_q;
        end else begin
          max_score_d = max_score_q;
          max_class_d = max_class_q;
        end
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_OUT;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_COUNT;
        end
      end
      ST_OUT: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    inp_ready_d = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_OUT);
  end

  // State, datapath and registered handshake outputs; reset aborts any frame in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      frame_q     <= '0;
      idx_q       <= '0;
      max_score_q <= '0;
      max_class_q <= '0;
      inp_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      idx_q       <= idx_d;
      max_score_q <= max_score_d;
      max_class_q <= max_class_d;
      inp_ready_q <= inp_ready_d;
      out_valid_q <= out_valid_d;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        acc_q[c] <= acc_d[c];
      end
    end
  end

  assign inp_ready_o = inp_ready_q;
  assign out_valid_o = out_valid_q;
  assign class_out_o = max_class_q;
  assign score_o     = max_score_q;

endmodule

// File: tb/tb_output_accumulator_classifier_folded.sv
// Bench for output_accumulator_classifier_folded: three instances
// (baseline, 4-bit saturating, frame mode) driven by directed frames and
// checked against a per-class accumulator model.
module tb_output_accumulator_classifier_folded;

  logic        clk;
  logic        rst;
  logic [39:0] net   [3];
  logic        inv   [3];
  logic        clr   [3];
  logic        ordy  [3];
  logic        irdy  [3];
  logic        ov    [3];
  logic [1:0]  cls   [3];
  logic [7:0]  scr   [3];
  logic [3:0]  scr1_s;

  int checks   = 0;
  int failures = 0;

  // Model state: accumulator values per instance and class, and the expected result.
  int macc    [3][4];
  int exp_cls [3];
  int exp_scr [3];
  int last_cls[3];
  int last_scr[3];
  int dsh     [3] = '{2, 2, 0};
  int amax    [3] = '{255, 15, 255};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  output_accumulator_classifier_folded #(
    .NET_WIDTH(40), .NUM_CLASSES(4), .ACC_WIDTH(8), .DECAY_SHIFT(2)
  ) u_base (
    .clk_i(clk), .reset_i(rst), .net_i(net[0]), .inp_valid_i(inv[0]),
    .inp_ready_o(irdy[0]), .clear_i(clr[0]), .class_out_o(cls[0]),
    .score_o(scr[0]), .out_valid_o(ov[0]), .out_ready_i(ordy[0])
  );

  output_accumulator_classifier_folded #(
    .NET_WIDTH(40), .NUM_CLASSES(4), .ACC_WIDTH(4), .DECAY_SHIFT(2)
  ) u_sat (
    .clk_i(clk), .reset_i(rst), .net_i(net[1]), .inp_valid_i(inv[1]),
    .inp_ready_o(irdy[1]), .clear_i(clr[1]), .class_out_o(cls[1]),
    .score_o(scr1_s), .out_valid_o(ov[1]), .out_ready_i(ordy[1])
  );
  assign scr[1] = {4'd0, scr1_s};

  output_accumulator_classifier_folded #(
    .NET_WIDTH(40), .NUM_CLASSES(4), .ACC_WIDTH(8), .DECAY_SHIFT(0)
  ) u_frame (
    .clk_i(clk), .reset_i(rst), .net_i(net[2]), .inp_valid_i(inv[2]),
    .inp_ready_o(irdy[2]), .clear_i(clr[2]), .class_out_o(cls[2]),
    .score_o(scr[2]), .out_valid_o(ov[2]), .out_ready_i(ordy[2])
  );

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endfunction

  // Frame whose group g has its lowest p[g] bits set.
  function automatic logic [39:0] mk(int p0, int p1, int p2, int p3);
    logic [39:0] f;
    int p[4];
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    f = '0;
    for (int g = 0; g < 4; g++) begin
      for (int b = 0; b < p[g]; b++) begin
        f[g*10 + b] = 1'b1;
      end
    end
    return f;
  endfunction

  // Apply the classifier rules to one frame and record the expected result.
  function automatic void model_frame(int k, logic [39:0] f, bit c);
    int pop, best, bc;
    if (c) begin
      for (int i = 0; i < 4; i++) macc[k][i] = 0;
    end
    best = 0;
    bc   = 0;
    for (int i = 0; i < 4; i++) begin
      pop = $countones(f[i*10 +: 10]);
      macc[k][i] = macc[k][i] - (macc[k][i] >> dsh[k]) + pop;
      if (macc[k][i] > amax[k]) macc[k][i] = amax[k];
      if (macc[k][i] > best) begin
        best = macc[k][i];
        bc   = i;
      end
    end
    exp_cls[k] = bc;
    exp_scr[k] = best;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) macc[k][i] = 0;
      exp_cls[k] = 0;
      exp_scr[k] = 0;
    end
  endfunction

  // Present a frame from a negedge and let the next posedge accept it.
  task automatic accept(input int k, input logic [39:0] f, input bit c);
    int n;
    n = 0;
    while (!irdy[k] && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", int'(irdy[k]), 1);
    net[k] = f;
    inv[k] = 1'b1;
    clr[k] = c;
    @(posedge clk);
    model_frame(k, f, c);
    #1;
    inv[k] = 1'b0;
    clr[k] = 1'b0;
  endtask

  // Wait for the result, optionally stall the consumer, then release it.
  task automatic wait_result(input int k, input int hold);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    ordy[k] = (hold == 0);
    while (!seen && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ov[k]) seen = 1'b1;
      else chk("busy_ready_low", int'(irdy[k]), 0);
    end
    chk("latency", n, 4);
    chk("out_ready_low", int'(irdy[k]), 0);
    last_cls[k] = int'(cls[k]);
    last_scr[k] = int'(scr[k]);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", int'(ov[k]), 1);
      chk("hold_ready", int'(irdy[k]), 0);
      chk("hold_class", int'(cls[k]), last_cls[k]);
      chk("hold_score", int'(scr[k]), last_scr[k]);
    end
    ordy[k] = 1'b1;
    @(negedge clk);
    chk("idle_valid", int'(ov[k]), 0);
    chk("idle_ready", int'(irdy[k]), 1);
  endtask

  // Whenever a result is offered it must match the model.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (ov[k]) begin
          chk("cmp_class", int'(cls[k]), exp_cls[k]);
          chk("cmp_score", int'(scr[k]), exp_scr[k]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      net[k] = '0; inv[k] = 1'b0; clr[k] = 1'b0; ordy[k] = 1'b1;
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", int'(irdy[k]), 1);
      chk("rst_valid", int'(ov[k]), 0);
      chk("rst_class", int'(cls[k]), 0);
      chk("rst_score", int'(scr[k]), 0);
    end

    // Single frame: popcounts 3,7,7,1 -> class 1 score 7
    accept(0, mk(3, 7, 7, 1), 1'b0);
    wait_result(0, 0);
    chk("t1_model_class", exp_cls[0], 1);
    chk("t1_model_score", exp_scr[0], 7);
    chk("t1_class", last_cls[0], 1);
    chk("t1_score", last_scr[0], 7);

    // Clear with frame 0,0,2,0 -> class 2 score 2
    accept(0, mk(0, 0, 2, 0), 1'b1);
    wait_result(0, 0);
    chk("clr_class", last_cls[0], 2);
    chk("clr_score", last_scr[0], 2);

    // Decay and tie-break
    accept(0, mk(0, 0, 0, 10), 1'b1);
    wait_result(0, 0);
    chk("decA_class", last_cls[0], 3);
    chk("decA_score", last_scr[0], 10);
    accept(0, mk(8, 0, 0, 0), 1'b0);
    wait_result(0, 0);
    chk("decB_class", last_cls[0], 0);
    chk("decB_score", last_scr[0], 8);

    // Backpressure with the next frame held on the input
    accept(0, mk(0, 5, 0, 0), 1'b0);
    net[0] = mk(1, 0, 0, 0);
    inv[0] = 1'b1;
    wait_result(0, 5);
    chk("bp_class", last_cls[0], 0);
    chk("bp_score", last_scr[0], 6);
    accept(0, mk(1, 0, 0, 0), 1'b0);
    wait_result(0, 0);
    chk("bp_next_score", last_scr[0], 6);

    // Saturation at 4 bits
    accept(1, mk(10, 0, 0, 0), 1'b0);
    wait_result(1, 0);
    chk("sat1_score", last_scr[1], 10);
    accept(1, mk(10, 0, 0, 0), 1'b0);
    wait_result(1, 0);
    chk("sat2_class", last_cls[1], 0);
    chk("sat2_score", last_scr[1], 15);

    // Frame mode: no history
    for (int r = 0; r < 2; r++) begin
      accept(2, mk(3, 7, 7, 1), 1'b0);
      wait_result(2, 0);
      chk("fm_class", last_cls[2], 1);
      chk("fm_score", last_scr[2], 7);
    end

    // Reset mid-COUNT
    accept(0, mk(3, 7, 7, 1), 1'b0);
    @(negedge clk);
    chk("abort_no_valid", int'(ov[0]), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk("abort_ready", int'(irdy[0]), 1);
    chk("abort_valid", int'(ov[0]), 0);
    chk("abort_class", int'(cls[0]), 0);
    chk("abort_score", int'(scr[0]), 0);
    repeat (2) @(negedge clk);
    chk("abort_hold_valid", int'(ov[0]), 0);
    rst = 1'b0;
    accept(0, mk(3, 7, 7, 1), 1'b0);
    wait_result(0, 0);
    chk("post_rst_class", last_cls[0], 1);
    chk("post_rst_score", last_scr[0], 7);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
